// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path.
// Holds the unit tag encoding used to label results from the four ALU units,
// plus a helper that gives the width of one packed collector entry
// ({unit tag, carry, data}) for a given data-field width.
package alu_pkg;

   localparam int UNIT_W = 2;

   // Tag values double as the arbitration order: lower tag wins when
   // several units flag a result in the same cycle.
   typedef enum logic [UNIT_W-1:0] {
      UNIT_ARITH = 2'd0,
      UNIT_LOGIC = 2'd1,
      UNIT_CMP   = 2'd2,
      UNIT_SHIFT = 2'd3
   } unit_e;

   // Packed entry layout, MSB first: unit tag, carry bit, data field.
   function automatic int entryWidth(input int dataW);
      return UNIT_W + 1 + dataW;
   endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Generic synchronous FIFO with a registered head.
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset, empties the FIFO
//   push_i       write pushData_i this cycle (dropped if full and not popping)
//   pushData_i   entry to write
//   pop_i        consume the head this cycle (ignored while empty)
//   full_o       FIFO holds DEPTH entries
//   empty_o      FIFO holds no entries
//   level_o      current occupancy, 0..DEPTH
//   headData_o   oldest entry, forced to zero while empty
//   overflow_o   push refused this cycle because the FIFO was full
module alu_res_fifo
   import alu_pkg::*;
#(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           pushData_i,
   input  logic                       pop_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic [WIDTH-1:0]           headData_o,
   output logic                       overflow_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             doPush;
   logic             doPop;

   // A pop frees a slot in the same edge, so a full FIFO can still accept a
   // push when it is also being drained; only a push with no pop is refused.
   always_comb begin
      empty_o    = (level_q == '0);
      full_o     = (level_q == LVL_W'(DEPTH));
      doPop      = pop_i && !empty_o;
      doPush     = push_i && (!full_o || doPop);
      overflow_o = push_i && full_o && !doPop;
   end

   // Pointers are power-of-two sized so they wrap on their own; the level
   // only moves when exactly one of push/pop takes effect.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      level_d = level_q;
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         level_q <= level_d;
      end
   end

   // Storage needs no reset: unread slots are never visible because the
   // head is masked while empty.
   always_ff @(posedge clk_i) begin
      if (doPush && !rst_i) mem_q[wrPtr_q] <= pushData_i;
   end

   // Head comes straight from storage, so a push is visible one edge later
   // at the earliest; nothing is bypassed combinationally.
   always_comb begin
      headData_o = empty_o ? '0 : mem_q[rdPtr_q];
      level_o    = level_q;
   end

endmodule

// File: rtl/alu_result_collector.sv
// Collects per-unit ALU results into a tagged FIFO and drains them to a
// consumer over a valid/ready handshake.
// Ports:
//   CLK_RES, RST_RES                clock and synchronous active-high reset
//   ARITH/LOGIC/CMP/SHIFT_Flag_RES  unit result valid strobes
//   ARITH_OUT_RES, Carry_out_RES    arithmetic result and carry
//   LOGIC_OUT_RES, CMP_OUT_RES,
//   SHIFT_OUT_RES                   narrower unit results (zero-extended)
//   OUT_VALID_RES / OUT_READY_RES   head handshake
//   OUT_UNIT_RES, OUT_CARRY_RES,
//   OUT_DATA_RES                    head entry fields
//   LEVEL_RES                       FIFO occupancy
//   OVF_ERR_RES                     sticky: a result was dropped on a full FIFO
//   MULTI_ERR_RES                   sticky: more than one flag in one cycle
module alu_result_collector
   import alu_pkg::*;
#(
   parameter int A_width_RES    = 16,
   parameter int B_width_RES    = 16,
   parameter int DATA_width_RES = A_width_RES + B_width_RES,
   parameter int FIFO_DEPTH_RES = 4
) (
   input  logic                          CLK_RES,
   input  logic                          RST_RES,
   input  logic                          ARITH_Flag_RES,
   input  logic                          LOGIC_Flag_RES,
   input  logic                          CMP_Flag_RES,
   input  logic                          SHIFT_Flag_RES,
   input  logic [DATA_width_RES-1:0]     ARITH_OUT_RES,
   input  logic                          Carry_out_RES,
   input  logic [A_width_RES-1:0]        LOGIC_OUT_RES,
   input  logic [2:0]                    CMP_OUT_RES,
   input  logic [A_width_RES-1:0]        SHIFT_OUT_RES,
   output logic                          OUT_VALID_RES,
   input  logic                          OUT_READY_RES,
   output logic [1:0]                    OUT_UNIT_RES,
   output logic                          OUT_CARRY_RES,
   output logic [DATA_width_RES-1:0]     OUT_DATA_RES,
   output logic [$clog2(FIFO_DEPTH_RES):0] LEVEL_RES,
   output logic                          OVF_ERR_RES,
   output logic                          MULTI_ERR_RES
);

   localparam int ENTRY_W = entryWidth(DATA_width_RES);

   logic                      anyFlag;
   logic                      multiFlag;
   unit_e                     pushUnit;
   logic                      pushCarry;
   logic [DATA_width_RES-1:0] pushData;
   logic [ENTRY_W-1:0]        pushEntry;
   logic [ENTRY_W-1:0]        headEntry;
   logic                      fifoFull;
   logic                      fifoEmpty;
   logic                      fifoOverflow;
   logic                      ovfErr_q, ovfErr_d;
   logic                      multiErr_q, multiErr_d;

   // Fixed-priority pick of one unit per cycle; narrower results are
   // zero-extended and carry only travels with arithmetic results.
   always_comb begin
      pushUnit  = UNIT_ARITH;
      pushCarry = 1'b0;
      pushData  = '0;
      if (ARITH_Flag_RES) begin
         pushUnit  = UNIT_ARITH;
         pushCarry = Carry_out_RES;
         pushData  = ARITH_OUT_RES;
      end else if (LOGIC_Flag_RES) begin
         pushUnit  = UNIT_LOGIC;
         pushData  = DATA_width_RES'(LOGIC_OUT_RES);
      end else if (CMP_Flag_RES) begin
         pushUnit  = UNIT_CMP;
         pushData  = DATA_width_RES'(CMP_OUT_RES);
      end else if (SHIFT_Flag_RES) begin
         pushUnit  = UNIT_SHIFT;
         pushData  = DATA_width_RES'(SHIFT_OUT_RES);
      end
      pushEntry = {pushUnit, pushCarry, pushData};
   end

   // Any pairwise overlap of the strobes means a result was lost to arbitration.
   always_comb begin
      anyFlag   = ARITH_Flag_RES | LOGIC_Flag_RES | CMP_Flag_RES | SHIFT_Flag_RES;
      multiFlag = (ARITH_Flag_RES & LOGIC_Flag_RES) | (ARITH_Flag_RES & CMP_Flag_RES) |
                  (ARITH_Flag_RES & SHIFT_Flag_RES) | (LOGIC_Flag_RES & CMP_Flag_RES) |
                  (LOGIC_Flag_RES & SHIFT_Flag_RES) | (CMP_Flag_RES & SHIFT_Flag_RES);
   end

   alu_res_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH_RES)
   ) u_fifo (
      .clk_i      (CLK_RES),
      .rst_i      (RST_RES),
      .push_i     (anyFlag),
      .pushData_i (pushEntry),
      .pop_i      (OUT_READY_RES),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty),
      .level_o    (LEVEL_RES),
      .headData_o (headEntry),
      .overflow_o (fifoOverflow)
   );

   // Error flags only ever accumulate; reset is the sole way to clear them.
   always_comb begin
      ovfErr_d   = ovfErr_q | fifoOverflow;
      multiErr_d = multiErr_q | multiFlag;
   end

   always_ff @(posedge CLK_RES) begin
      if (RST_RES) begin
         ovfErr_q   <= 1'b0;
         multiErr_q <= 1'b0;
      end else begin
         ovfErr_q   <= ovfErr_d;
         multiErr_q <= multiErr_d;
      end
   end

   // Head fields are unpacked from the registered FIFO head; the FIFO
   // already zeroes the head while empty.
   always_comb begin
      OUT_VALID_RES = !fifoEmpty;
      OUT_UNIT_RES  = headEntry[ENTRY_W-1 -: 2];
      OUT_CARRY_RES = headEntry[DATA_width_RES];
      OUT_DATA_RES  = headEntry[DATA_width_RES-1:0];
      OVF_ERR_RES   = ovfErr_q;
      MULTI_ERR_RES = multiErr_q;
   end

   // fifoFull is only needed for the overflow decision inside the FIFO.
   logic unusedFull;
   assign unusedFull = fifoFull;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed, table-driven bench for alu_result_collector with default widths
// (32-bit data, depth 4). Each table row drives one cycle of inputs and lists
// the outputs expected just after the following rising edge.
module tb_alu_result_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic        aFlag, lFlag, cFlag, sFlag;
   logic [31:0] arithOut;
   logic        carryIn;
   logic [15:0] logicOut;
   logic [2:0]  cmpOut;
   logic [15:0] shiftOut;
   logic        ready;
   logic        outValid;
   logic [1:0]  outUnit;
   logic        outCarry;
   logic [31:0] outData;
   logic [2:0]  level;
   logic        ovfErr;
   logic        multiErr;

   int tests    = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic        rst;
      logic [3:0]  flags;
      logic [31:0] arith;
      logic        carry;
      logic [15:0] logicV;
      logic [2:0]  cmpV;
      logic [15:0] shiftV;
      logic        ready;
      logic        expValid;
      logic [1:0]  expUnit;
      logic        expCarry;
      logic [31:0] expData;
      logic [2:0]  expLevel;
      logic        expOvf;
      logic        expMulti;
   } vec_t;

   vec_t vecs[$];

   alu_result_collector dut (
      .CLK_RES        (clk),
      .RST_RES        (rst),
      .ARITH_Flag_RES (aFlag),
      .LOGIC_Flag_RES (lFlag),
      .CMP_Flag_RES   (cFlag),
      .SHIFT_Flag_RES (sFlag),
      .ARITH_OUT_RES  (arithOut),
      .Carry_out_RES  (carryIn),
      .LOGIC_OUT_RES  (logicOut),
      .CMP_OUT_RES    (cmpOut),
      .SHIFT_OUT_RES  (shiftOut),
      .OUT_VALID_RES  (outValid),
      .OUT_READY_RES  (ready),
      .OUT_UNIT_RES   (outUnit),
      .OUT_CARRY_RES  (outCarry),
      .OUT_DATA_RES   (outData),
      .LEVEL_RES      (level),
      .OVF_ERR_RES    (ovfErr),
      .MULTI_ERR_RES  (multiErr)
   );

   always #5 clk = ~clk;

   task automatic addVec(input string name, input logic r, input logic [3:0] f,
                         input logic [31:0] a, input logic c, input logic [15:0] lv,
                         input logic [2:0] cv, input logic [15:0] sv, input logic rdy,
                         input logic ev, input logic [1:0] eu, input logic ec,
                         input logic [31:0] ed, input logic [2:0] el,
                         input logic eo, input logic em);
      vec_t v;
      v.name = name; v.rst = r; v.flags = f; v.arith = a; v.carry = c;
      v.logicV = lv; v.cmpV = cv; v.shiftV = sv; v.ready = rdy;
      v.expValid = ev; v.expUnit = eu; v.expCarry = ec; v.expData = ed;
      v.expLevel = el; v.expOvf = eo; v.expMulti = em;
      vecs.push_back(v);
   endtask

   // Drives one cycle of inputs, then waits for the edge and settles past it.
   task automatic applyStimulus(input vec_t v);
      rst      = v.rst;
      {aFlag, lFlag, cFlag, sFlag} = v.flags;
      arithOut = v.arith;
      carryIn  = v.carry;
      logicOut = v.logicV;
      cmpOut   = v.cmpV;
      shiftOut = v.shiftV;
      ready    = v.ready;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic ev, input logic [1:0] eu,
                              input logic ec, input logic [31:0] ed, input logic [2:0] el,
                              input logic eo, input logic em);
      tests++;
      if ({outValid, outUnit, outCarry, outData, level, ovfErr, multiErr} !==
          {ev, eu, ec, ed, el, eo, em}) begin
         failures++;
         $display("[TB] FAIL %s: got v=%0b u=%0d c=%0b d=%h lvl=%0d ovf=%0b multi=%0b, expected v=%0b u=%0d c=%0b d=%h lvl=%0d ovf=%0b multi=%0b",
                  name, outValid, outUnit, outCarry, outData, level, ovfErr, multiErr,
                  ev, eu, ec, ed, el, eo, em);
      end
   endtask

   initial begin
      // flags order {ARITH, LOGIC, CMP, SHIFT}
      //      name        rst flags    arith        c  logic    cmp   shift    rdy | v u c data          lvl ovf mul
      addVec("rst0",       1, 4'b1111, 32'h1,       1, 16'h1,   3'h1, 16'h1,   1,  0, 0, 0, 32'h0,        0, 0, 0);
      addVec("rst1",       1, 4'b0101, 32'h2,       0, 16'h2,   3'h2, 16'h2,   0,  0, 0, 0, 32'h0,        0, 0, 0);
      addVec("arith",      0, 4'b1000, 32'h0001FFFE,1, 16'h0,   3'h0, 16'h0,   1,  1, 0, 1, 32'h0001FFFE, 1, 0, 0);
      addVec("arithPop",   0, 4'b0000, 32'h0,       0, 16'h0,   3'h0, 16'h0,   1,  0, 0, 0, 32'h0,        0, 0, 0);
      addVec("logicZx",    0, 4'b0100, 32'h0,       1, 16'hA5A5,3'h0, 16'h0,   0,  1, 1, 0, 32'h0000A5A5, 1, 0, 0);
      addVec("cmpZx",      0, 4'b0010, 32'h0,       1, 16'h0,   3'b100,16'h0,  1,  1, 2, 0, 32'h00000004, 1, 0, 0);
      addVec("cmpPop",     0, 4'b0000, 32'h0,       0, 16'h0,   3'h0, 16'h0,   1,  0, 0, 0, 32'h0,        0, 0, 0);
      addVec("shift1",     0, 4'b0001, 32'h0,       0, 16'h0,   3'h0, 16'd1,   0,  1, 3, 0, 32'd1,        1, 0, 0);
      addVec("shift2",     0, 4'b0001, 32'h0,       0, 16'h0,   3'h0, 16'd2,   0,  1, 3, 0, 32'd1,        2, 0, 0);
      addVec("shift3",     0, 4'b0001, 32'h0,       0, 16'h0,   3'h0, 16'd3,   0,  1, 3, 0, 32'd1,        3, 0, 0);
      addVec("shift4",     0, 4'b0001, 32'h0,       0, 16'h0,   3'h0, 16'd4,   0,  1, 3, 0, 32'd1,        4, 0, 0);
      addVec("shift5Ovf",  0, 4'b0001, 32'h0,       0, 16'h0,   3'h0, 16'd5,   0,  1, 3, 0, 32'd1,        4, 1, 0);
      addVec("drain1",     0, 4'b0000, 32'h0,       0, 16'h0,   3'h0, 16'h0,   1,  1, 3, 0, 32'd2,        3, 1, 0);
      addVec("drain2",     0, 4'b0000, 32'h0,       0, 16'h0,   3'h0, 16'h0,   1,  1, 3, 0, 32'd3,        2, 1, 0);
      addVec("drain3",     0, 4'b0000, 32'h0,       0, 16'h0,   3'h0, 16'h0,   1,  1, 3, 0, 32'd4,        1, 1, 0);
      addVec("drain4",     0, 4'b0000, 32'h0,       0, 16'h0,   3'h0, 16'h0,   1,  0, 0, 0, 32'h0,        0, 1, 0);
      addVec("rstOvf",     1, 4'b0000, 32'h0,       0, 16'h0,   3'h0, 16'h0,   0,  0, 0, 0, 32'h0,        0, 0, 0);
      addVec("fillA",      0, 4'b0001, 32'h0,       0, 16'h0,   3'h0, 16'h11,  0,  1, 3, 0, 32'h11,       1, 0, 0);
      addVec("fillB",      0, 4'b0001, 32'h0,       0, 16'h0,   3'h0, 16'h22,  0,  1, 3, 0, 32'h11,       2, 0, 0);
      addVec("fillC",      0, 4'b0001, 32'h0,       0, 16'h0,   3'h0, 16'h33,  0,  1, 3, 0, 32'h11,       3, 0, 0);
      addVec("fillD",      0, 4'b0001, 32'h0,       0, 16'h0,   3'h0, 16'h44,  0,  1, 3, 0, 32'h11,       4, 0, 0);
      addVec("fullPushPop",0, 4'b0001, 32'h0,       0, 16'h0,   3'h0, 16'h55,  1,  1, 3, 0, 32'h22,       4, 0, 0);
      addVec("fpDrain1",   0, 4'b0000, 32'h0,       0, 16'h0,   3'h0, 16'h0,   1,  1, 3, 0, 32'h33,       3, 0, 0);
      addVec("fpDrain2",   0, 4'b0000, 32'h0,       0, 16'h0,   3'h0, 16'h0,   1,  1, 3, 0, 32'h44,       2, 0, 0);
      addVec("fpDrain3",   0, 4'b0000, 32'h0,       0, 16'h0,   3'h0, 16'h0,   1,  1, 3, 0, 32'h55,       1, 0, 0);
      addVec("fpDrain4",   0, 4'b0000, 32'h0,       0, 16'h0,   3'h0, 16'h0,   1,  0, 0, 0, 32'h0,        0, 0, 0);
      addVec("multiAC",    0, 4'b1010, 32'h12345678,0, 16'h0,   3'b010,16'h0,  0,  1, 0, 0, 32'h12345678, 1, 0, 1);
      addVec("multiLogic", 0, 4'b0100, 32'h0,       0, 16'h00FF,3'h0, 16'h0,   0,  1, 0, 0, 32'h12345678, 2, 0, 1);
      addVec("multiPop",   0, 4'b0000, 32'h0,       0, 16'h0,   3'h0, 16'h0,   1,  1, 1, 0, 32'h000000FF, 1, 0, 1);
      addVec("rstMid",     1, 4'b0001, 32'h0,       0, 16'h0,   3'h0, 16'h7,   1,  0, 0, 0, 32'h0,        0, 0, 0);
      addVec("readyEmpty", 0, 4'b0000, 32'h0,       0, 16'h0,   3'h0, 16'h0,   1,  0, 0, 0, 32'h0,        0, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i].name, vecs[i].expValid, vecs[i].expUnit, vecs[i].expCarry,
                     vecs[i].expData, vecs[i].expLevel, vecs[i].expOvf, vecs[i].expMulti);
      end

      // Head must hold steady across several stalled cycles, then pop cleanly.
      begin
         vec_t v;
         v = vecs[vecs.size()-1];
         v.flags = 4'b0001; v.shiftV = 16'hBEEF; v.ready = 1'b0;
         applyStimulus(v);
         checkOutput("stallPush", 1, 3, 0, 32'h0000BEEF, 1, 0, 0);
         v.flags = 4'b0000;
         for (int k = 0; k < 3; k++) begin
            applyStimulus(v);
            checkOutput("stallHold", 1, 3, 0, 32'h0000BEEF, 1, 0, 0);
         end
         v.ready = 1'b1;
         applyStimulus(v);
         checkOutput("stallPop", 0, 0, 0, 32'h0, 0, 0, 0);

         // CMP beats SHIFT when both fire; the loss is recorded.
         v.flags = 4'b0011; v.cmpV = 3'b101; v.shiftV = 16'h0007; v.ready = 1'b0;
         applyStimulus(v);
         checkOutput("multiCS", 1, 2, 0, 32'h00000005, 1, 0, 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
